sprite_motion_ctrl: RTL and testbench



---
 rtl/sprite_motion_if.sv | 22 ++
 rtl/sprite_motion_ctrl.sv | 85 ++++++++
 tb/tb_sprite_motion_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_if.sv
// sprite_motion_if: control inputs and position outputs of the sprite motion controller
interface sprite_motion_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic       dir;
  logic [3:0] speed;
  logic [9:0] loc_h;
  logic [9:0] loc_v;
  logic [9:0] height;
  logic [9:0] width;
  logic       busy;
  logic       done;
  modport master (
    output frame_tick, start, pause, dir, speed,
    input  loc_h, loc_v, height, width, busy, done
  );
  modport slave (
    input  frame_tick, start, pause, dir, speed,
    output loc_h, loc_v, height, width, busy, done
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame rise/scroll/fall sequencer for one wrapping sprite
module sprite_motion_ctrl #(
  parameter int SCREEN_W      = 850,
  parameter int SPR_W         = 60,
  parameter int MAX_H         = 450,
  parameter int GROUND_V      = 480,
  parameter int H_STEP        = 10,
  parameter int SCROLL_FRAMES = 120,
  parameter int START_H       = 400
) (
  input logic           clk,
  input logic           rst,
  sprite_motion_if.slave bus
);
  localparam int CW = $clog2(SCROLL_FRAMES + 1);
  typedef enum logic [2:0] {IDLE, RISE, SCROLL, FALL, DONE} state_t;
  state_t        state_q, state_d;
  logic [9:0]    loc_h_q, loc_h_d, height_q, height_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          tick;
  logic [10:0]   h_ext, spd, dec_h, sum_h, inc_h, h_sum;
  logic [9:0]    h_up, h_dn;
  assign tick    = bus.frame_tick & ~bus.pause;
  assign h_ext   = {1'b0, loc_h_q};
  assign spd     = 11'(bus.speed);
  assign dec_h   = h_ext >= spd ? h_ext - spd : h_ext + 11'(SCREEN_W) - spd;
  assign sum_h   = h_ext + spd;
  assign inc_h   = sum_h >= 11'(SCREEN_W) ? sum_h - 11'(SCREEN_W) : sum_h;
  assign h_sum   = {1'b0, height_q} + 11'(H_STEP);
  assign h_up    = h_sum > 11'(MAX_H) ? 10'(MAX_H) : h_sum[9:0];
  assign h_dn    = height_q < 10'(H_STEP) ? '0 : height_q - 10'(H_STEP);
  assign cnt_inc = cnt_q + CW'(1);
  // sequence stepping: start is handled immediately, everything else only on applied ticks
  always_comb begin
    state_d  = state_q;
    loc_h_d  = loc_h_q;
    height_d = height_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = RISE;
        loc_h_d  = 10'(START_H);
        height_d = '0;
      end
      RISE: if (tick) begin
        height_d = h_up;
        if (h_up == 10'(MAX_H)) begin
          state_d = SCROLL;
          cnt_d   = '0;
        end
      end
      SCROLL: if (tick) begin
        loc_h_d = bus.dir ? inc_h[9:0] : dec_h[9:0];
        cnt_d   = cnt_inc;
        if (cnt_inc == CW'(SCROLL_FRAMES)) state_d = FALL;
      end
      FALL: if (tick) begin
        height_d = h_dn;
        if (h_dn == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and frame-boundary position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      loc_h_q  <= 10'(START_H);
      height_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      loc_h_q  <= loc_h_d;
      height_q <= height_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.loc_h  = loc_h_q;
  assign bus.loc_v  = 10'(GROUND_V) - height_q;
  assign bus.height = height_q;
  assign bus.width  = 10'(SPR_W);
  assign bus.busy   = state_q != IDLE;
  assign bus.done   = state_q == DONE;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: random and directed stimulus checked against a behavioural sprite model
module tb_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sprite_motion_if bus();
  sprite_motion_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  localparam int P_IDLE = 0, P_RISE = 1, P_SCROLL = 2, P_FALL = 3, P_DONE = 4;
  int ph = P_IDLE;
  int m_h = 400;
  int m_ht = 0;
  int m_frames = 0;
  bit m_valid = 1'b0;
  int tab [8][3] = '{'{0, 7, 3}, '{0, 7, 846}, '{0, 7, 839}, '{1, 1, 840},
                     '{1, 15, 5}, '{0, 15, 840}, '{0, 6, 834}, '{1, 15, 849}};

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // reference model: the sprite's sequence phase, position, height and frames scrolled
  always @(posedge clk) begin
    m_valid = 1'b1;
    if (rst) begin
      ph = P_IDLE; m_h = 400; m_ht = 0; m_frames = 0;
    end else begin
      case (ph)
        P_IDLE: if (bus.start) begin ph = P_RISE; m_h = 400; m_ht = 0; end
        P_RISE: if (bus.frame_tick && !bus.pause) begin
          m_ht = (m_ht + 10 > 450) ? 450 : m_ht + 10;
          if (m_ht == 450) begin ph = P_SCROLL; m_frames = 0; end
        end
        P_SCROLL: if (bus.frame_tick && !bus.pause) begin
          m_h = (((m_h + (bus.dir ? int'(bus.speed) : -int'(bus.speed))) % 850) + 850) % 850;
          m_frames++;
          if (m_frames == 120) ph = P_FALL;
        end
        P_FALL: if (bus.frame_tick && !bus.pause) begin
          m_ht = (m_ht < 10) ? 0 : m_ht - 10;
          if (m_ht == 0) ph = P_DONE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) if (m_valid) begin
    chk("loc_h", int'(bus.loc_h), m_h);
    chk("height", int'(bus.height), m_ht);
    chk("loc_v", int'(bus.loc_v), 480 - m_ht);
    chk("width", int'(bus.width), 60);
    chk("busy", int'(bus.busy), int'(ph != P_IDLE));
    chk("done", int'(bus.done), int'(ph == P_DONE));
    chk("loc_h_range", int'(bus.loc_h < 10'd850), 1);
  end

  task automatic tick(input bit p, input bit d, input int s);
    bus.frame_tick = 1'b1; bus.pause = p; bus.dir = d; bus.speed = 4'(s);
    @(posedge clk); #1;
    bus.frame_tick = 1'b0; bus.pause = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_applied(input int n);
    int k = 0;
    while (k < n) begin
      bit p = ($urandom_range(0, 3) == 0);
      tick(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      if (!p) k++;
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.dir = 1'b0; bus.speed = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_loc_h", int'(bus.loc_h), 400);
    chk("rst_height", int'(bus.height), 0);
    chk("rst_loc_v", int'(bus.loc_v), 480);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    pulse_start();
    bus.frame_tick = 1'b0;
    chk("start_busy", int'(bus.busy), 1);
    chk("start_tick_height", int'(bus.height), 0);
    for (int i = 1; i <= 45; i++) begin
      tick(1'b0, 1'b0, 5);
      chk("rise_height", int'(bus.height), 10 * i);
      chk("rise_loc_v", int'(bus.loc_v), 480 - 10 * i);
      chk("rise_loc_h", int'(bus.loc_h), 400);
      if (i == 10) begin
        pulse_start();
        chk("rise_start_ignored", int'(bus.height), 100);
      end
    end
    repeat (26) tick(1'b0, 1'b0, 15);
    chk("scroll_dec", int'(bus.loc_h), 10);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, tab[i][0] != 0, tab[i][1]);
      chk("scroll_wrap", int'(bus.loc_h), tab[i][2]);
    end
    repeat (5) begin
      tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, 15)));
      chk("pause_hold", int'(bus.loc_h), 849);
    end
    run_applied(84);
    tick(1'b0, 1'b1, 1);
    chk("scroll_119", int'(bus.height), 450);
    tick(1'b0, 1'b1, 0);
    chk("scroll_120", int'(bus.height), 450);
    for (int i = 1; i <= 45; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      chk("fall_height", int'(bus.height), 450 - 10 * i);
    end
    chk("done_pulse", int'(bus.done), 1);
    chk("done_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    chk("done_clear", int'(bus.done), 0);
    chk("idle_busy", int'(bus.busy), 0);
    pulse_start();
    run_applied(45);
    run_applied(120);
    run_applied(25);
    chk("fall_200", int'(bus.height), 200);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_height", int'(bus.height), 0);
    chk("abort_loc_v", int'(bus.loc_v), 480);
    chk("abort_loc_h", int'(bus.loc_h), 400);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (6000) begin
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.start = ($urandom_range(0, 40) == 0);
      bus.pause = ($urandom_range(0, 3) == 0);
      bus.dir = 1'($urandom_range(0, 1));
      bus.speed = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 1500) == 0);
      @(posedge clk); #1;
    end
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
